time_set_editor: RTL and testbench
==================================

// Module: time_set_editor
// PURPOSE
//   Input-side counterpart of the clock display path. Debounces the five panel
//   buttons and runs the time-setting editor. On confirm it emits a one-cycle
//   load strobe with a complete, validated date/time for current_time to take.
//   It sits between the raw button pins and the time counter. The divider
//   supplies tick_ms; current_time supplies the cur_* snapshot.
// PARAMETERS
//   DEBOUNCE_MS  20    consecutive equal tick_ms samples before a button level is accepted
//   YEAR_MIN     2000  lowest editable year (inclusive)
//   YEAR_MAX     2099  highest editable year (inclusive)
// PORTS
//   clk          in   1   system clock; all logic is on its rising edge
//   rst          in   1   synchronous, active-high reset
//   tick_ms      in   1   1 kHz single-cycle strobe; button sample enable
//   up/down      in   1   raw button levels, active-high, asynchronous
//   left/right   in   1   raw button levels, active-high, asynchronous
//   middle       in   1   raw button level, active-high, asynchronous
//   cur_year     in   16  live year, captured when an edit starts
//   cur_month    in   6   live month 1..12
//   cur_day      in   11  live day 1..31
//   cur_hour     in   11  live hour 0..23
//   cur_minute   in   11  live minute 0..59
//   cur_second   in   11  live second 0..59
//   edit_active  out  1   high while in EDIT; display shows edit_* and blinks edit_field
//   edit_field   out  3   0=year 1=month 2=day 3=hour 4=minute 5=second
//   edit_year    out  16  edited value; edit_month is 6 bits, the rest are 11 bits
//   edit_month   out  6   edited month
//   edit_day     out  11  edited day
//   edit_hour    out  11  edited hour
//   edit_minute  out  11  edited minute
//   edit_second  out  11  edited second
//   load         out  1   one-cycle strobe; edit_* is valid in the same cycle
// BEHAVIOUR
//   Input synchronisation
//   - Each raw button passes through a 2-FF synchroniser.
//   Debounce (per button)
//   - Sampled only on tick_ms cycles.
//   - The counter resets to 0 when the sample equals the accepted level.
//   - Otherwise it increments. On reaching DEBOUNCE_MS the accepted level flips
//     and the counter clears.
//   - A press event is a 1-cycle pulse in the cycle after the accepted level
//     rises 0->1. A release generates nothing, and holding gives no auto-repeat.
//   Event priority within one cycle
//   - middle > left/right > up/down. Lower-priority events in that cycle are
//     dropped.
//   - left+right together, or up+down together, are both ignored.
//   FSM IDLE
//   - A middle event copies cur_* into edit_*.
//   - The copy saturates into legal range: year clamps to [YEAR_MIN,YEAR_MAX],
//     and day clamps to days-in-month.
//   - It then sets edit_field=3 and enters EDIT. All other events are ignored.
//   FSM EDIT
//   - right: field+1, wrapping 5->0. left: field-1, wrapping 0->5.
//   - up: the selected field +1, wrapping max->min.
//   - down: the selected field -1, wrapping min->max.
//   - Field ranges: year YEAR_MIN..YEAR_MAX, month 1..12, day 1..dim(month,year),
//     hour 0..23, minute 0..59, second 0..59.
//   - middle: load=1 for exactly one cycle, then the FSM returns to IDLE.
//     edit_* holds its last value afterwards.
//   Days-in-month (dim)
//   - Months 4, 6, 9 and 11 have 30 days. Month 2 has 29 in a leap year, else 28.
//   - All other months have 31 days.
//   - Leap year: (y%4==0 && y%100!=0) || y%400==0.
//   - After any year or month change, day = min(day, new dim), applied in the
//     same update cycle.
//   Latency
//   - The edit_* change is visible 1 cycle after the press event.
//   - load asserts 1 cycle after the middle event.
//   Reset
//   - FSM to IDLE. load=0, edit_active=0, edit_field=3.
//   - edit_year=YEAR_MIN, month=1, day=1; hour, minute and second = 0.
//   - Debounce counters = 0, accepted levels = 0 (released).
//   - Reset during EDIT aborts the edit with no load.
//   Buttons held through reset
//   - A button held through reset must re-qualify for DEBOUNCE_MS and then
//     yields one press.
// TESTING
//   1. Bounce: middle toggles every 3 tick_ms for 15 ms, then holds high 25 ms
//      -> exactly one press, no FSM action before the hold qualifies.
//   2. Start edit: IDLE with cur=2023-02-28 23:59:59, press middle
//      -> edit_active=1, edit_field=3, edit_*=2023/2/28/23/59/59.
//   3. Wrap and field: on field 3, press up -> hour 0. Press left x4 -> field 5.
//      Press right -> field 0.
//   4. Day clamp: edit 2024-01-31, field 1, up -> month 2, day 29. Field 0, up
//      -> year 2025, day 28. Year 2099 up -> 2000.
//   5. Commit: press middle in EDIT -> load high exactly 1 cycle with 2025-02-28
//      values, edit_active=0 next cycle. up+down together -> no change.
//   6. Reset mid-edit: assert rst in EDIT -> no load, outputs at reset values
//      the next cycle.

Source files
------------

// File: rtl/time_set_editor.sv
// Panel-button front end for setting the clock. It debounces five buttons,
// edits a date/time snapshot, and strobes load with the validated result.
module time_set_editor #(
  parameter int DEBOUNCE_MS = 20,
  parameter int YEAR_MIN    = 2000,
  parameter int YEAR_MAX    = 2099
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_ms_i,
  input  logic        up_i,
  input  logic        down_i,
  input  logic        left_i,
  input  logic        right_i,
  input  logic        middle_i,
  input  logic [15:0] cur_year_i,
  input  logic [5:0]  cur_month_i,
  input  logic [10:0] cur_day_i,
  input  logic [10:0] cur_hour_i,
  input  logic [10:0] cur_minute_i,
  input  logic [10:0] cur_second_i,
  output logic        edit_active_o,
  output logic [2:0]  edit_field_o,
  output logic [15:0] edit_year_o,
  output logic [5:0]  edit_month_o,
  output logic [10:0] edit_day_o,
  output logic [10:0] edit_hour_o,
  output logic [10:0] edit_minute_o,
  output logic [10:0] edit_second_o,
  output logic        load_o
);
  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [15:0] Y_MIN = 16'(YEAR_MIN);
  localparam logic [15:0] Y_MAX = 16'(YEAR_MAX);
  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_MID = 4;
  localparam logic [2:0] F_YEAR = 3'd0, F_MONTH = 3'd1, F_DAY = 3'd2,
                         F_HOUR = 3'd3, F_MIN = 3'd4, F_SEC = 3'd5;

  typedef enum logic {S_IDLE, S_EDIT} state_e;

  function automatic logic is_leap(input logic [15:0] y);
    return (((y % 16'd4) == 16'd0) && ((y % 16'd100) != 16'd0)) || ((y % 16'd400) == 16'd0);
  endfunction

  function automatic logic [10:0] dim(input logic [5:0] m, input logic [15:0] y);
    case (m)
      6'd4, 6'd6, 6'd9, 6'd11: return 11'd30;
      6'd2:                    return is_leap(y) ? 11'd29 : 11'd28;
      default:                 return 11'd31;
    endcase
  endfunction

  function automatic logic [15:0] clamp16(input logic [15:0] v, input logic [15:0] lo,
                                          input logic [15:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [15:0] wrap_step(input logic [15:0] v, input logic [15:0] lo,
                                            input logic [15:0] hi, input logic inc);
    if (inc) return (v >= hi) ? lo : v + 16'd1;
    return (v <= lo) ? hi : v - 16'd1;
  endfunction

  logic [4:0]         raw, sync1_q, sync2_q, level_q, level_d, evt_q, evt_d;
  logic [4:0][CW-1:0] cnt_q, cnt_d;

  state_e      state_q, state_d;
  logic [2:0]  field_q, field_d;
  logic [15:0] year_q, year_d;
  logic [5:0]  month_q, month_d;
  logic [10:0] day_q, day_d, hour_q, hour_d, minute_q, minute_d, second_q, second_d;
  logic        load_q, load_d;
  logic [10:0] new_dim;

  assign raw = {middle_i, right_i, left_i, down_i, up_i};

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (tick_ms_i) begin
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CW'(DEBOUNCE_MS - 1)) begin
          level_d[i] = ~level_q[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    evt_d = level_d & ~level_q;
  end

  always_comb begin
    state_d  = state_q;
    field_d  = field_q;
    year_d   = year_q;
    month_d  = month_q;
    day_d    = day_q;
    hour_d   = hour_q;
    minute_d = minute_q;
    second_d = second_q;
    load_d   = 1'b0;
    new_dim  = 11'd31;
    case (state_q)
      S_IDLE: begin
        if (evt_q[B_MID]) begin
          year_d   = clamp16(cur_year_i, Y_MIN, Y_MAX);
          month_d  = 6'(clamp16({10'd0, cur_month_i}, 16'd1, 16'd12));
          new_dim  = dim(month_d, year_d);
          day_d    = 11'(clamp16({5'd0, cur_day_i}, 16'd1, {5'd0, new_dim}));
          hour_d   = 11'(clamp16({5'd0, cur_hour_i}, 16'd0, 16'd23));
          minute_d = 11'(clamp16({5'd0, cur_minute_i}, 16'd0, 16'd59));
          second_d = 11'(clamp16({5'd0, cur_second_i}, 16'd0, 16'd59));
          field_d  = F_HOUR;
          state_d  = S_EDIT;
        end
      end
      S_EDIT: begin
        if (evt_q[B_MID]) begin
          load_d  = 1'b1;
          state_d = S_IDLE;
        end else if (evt_q[B_LEFT] || evt_q[B_RIGHT]) begin
          // Any left/right activity shadows up/down; both together cancel out.
          if (evt_q[B_RIGHT] && !evt_q[B_LEFT])
            field_d = (field_q >= F_SEC) ? F_YEAR : field_q + 3'd1;
          else if (evt_q[B_LEFT] && !evt_q[B_RIGHT])
            field_d = (field_q == F_YEAR) ? F_SEC : field_q - 3'd1;
        end else if (evt_q[B_UP] ^ evt_q[B_DOWN]) begin
          case (field_q)
            F_YEAR:  year_d   = wrap_step(year_q, Y_MIN, Y_MAX, evt_q[B_UP]);
            F_MONTH: month_d  = 6'(wrap_step({10'd0, month_q}, 16'd1, 16'd12, evt_q[B_UP]));
            F_DAY:   day_d    = 11'(wrap_step({5'd0, day_q}, 16'd1,
                                               {5'd0, dim(month_q, year_q)}, evt_q[B_UP]));
            F_HOUR:  hour_d   = 11'(wrap_step({5'd0, hour_q}, 16'd0, 16'd23, evt_q[B_UP]));
            F_MIN:   minute_d = 11'(wrap_step({5'd0, minute_q}, 16'd0, 16'd59, evt_q[B_UP]));
            F_SEC:   second_d = 11'(wrap_step({5'd0, second_q}, 16'd0, 16'd59, evt_q[B_UP]));
            default: ;
          endcase
          if (field_q == F_YEAR || field_q == F_MONTH) begin
            new_dim = dim(month_d, year_d);
            day_d   = (day_q > new_dim) ? new_dim : day_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments; the comb blocks above use blocking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      evt_q    <= '0;
      state_q  <= S_IDLE;
      field_q  <= F_HOUR;
      year_q   <= Y_MIN;
      month_q  <= 6'd1;
      day_q    <= 11'd1;
      hour_q   <= '0;
      minute_q <= '0;
      second_q <= '0;
      load_q   <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
      state_q  <= state_d;
      field_q  <= field_d;
      year_q   <= year_d;
      month_q  <= month_d;
      day_q    <= day_d;
      hour_q   <= hour_d;
      minute_q <= minute_d;
      second_q <= second_d;
      load_q   <= load_d;
    end
  end

  assign edit_active_o = (state_q == S_EDIT);
  assign edit_field_o  = field_q;
  assign edit_year_o   = year_q;
  assign edit_month_o  = month_q;
  assign edit_day_o    = day_q;
  assign edit_hour_o   = hour_q;
  assign edit_minute_o = minute_q;
  assign edit_second_o = second_q;
  assign load_o        = load_q;

endmodule

// File: tb/tb_time_set_editor.sv
// Directed bench for time_set_editor: bounce, edit entry, field wrap, day clamp,
// commit, year wrap and reset behaviour, with hand-computed expected values.
module tb_time_set_editor;
  localparam int TICK_DIV = 4;
  localparam int HOLD_CYC = 25 * TICK_DIV;
  localparam logic [4:0] M_UP = 5'b00001, M_DOWN = 5'b00010, M_LEFT = 5'b00100,
                         M_RIGHT = 5'b01000, M_MID = 5'b10000;

  logic clk = 1'b0;
  logic rst, tick_ms;
  logic btn_up, btn_down, btn_left, btn_right, btn_mid;
  logic [15:0] cur_year;
  logic [5:0]  cur_month;
  logic [10:0] cur_day, cur_hour, cur_minute, cur_second;
  logic        edit_active, load;
  logic [2:0]  edit_field;
  logic [15:0] edit_year;
  logic [5:0]  edit_month;
  logic [10:0] edit_day, edit_hour, edit_minute, edit_second;
  logic [65:0] obs;

  int n_vec = 0;
  int n_err = 0;
  int load_cnt = 0;
  logic [65:0] load_snap = '0;

  time_set_editor dut (
    .clk_i(clk), .rst_i(rst), .tick_ms_i(tick_ms),
    .up_i(btn_up), .down_i(btn_down), .left_i(btn_left), .right_i(btn_right),
    .middle_i(btn_mid),
    .cur_year_i(cur_year), .cur_month_i(cur_month), .cur_day_i(cur_day),
    .cur_hour_i(cur_hour), .cur_minute_i(cur_minute), .cur_second_i(cur_second),
    .edit_active_o(edit_active), .edit_field_o(edit_field),
    .edit_year_o(edit_year), .edit_month_o(edit_month), .edit_day_o(edit_day),
    .edit_hour_o(edit_hour), .edit_minute_o(edit_minute), .edit_second_o(edit_second),
    .load_o(load)
  );

  assign obs = {edit_year, edit_month, edit_day, edit_hour, edit_minute, edit_second};

  always #5 clk = ~clk;

  initial begin
    tick_ms = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      tick_ms = 1'b1;
      @(negedge clk);
      tick_ms = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_cnt++;
      load_snap = obs;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no end of test expected finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [65:0] dt(input int y, input int mo, input int d,
                                     input int h, input int mi, input int s);
    return {16'(y), 6'(mo), 11'(d), 11'(h), 11'(mi), 11'(s)};
  endfunction

  function automatic string fmt(input logic [65:0] v);
    return $sformatf("%0d-%0d-%0d %0d:%0d:%0d", v[65:50], v[49:44], v[43:33],
                     v[32:22], v[21:11], v[10:0]);
  endfunction

  task automatic set_cur(input int y, input int mo, input int d,
                         input int h, input int mi, input int s);
    {cur_year, cur_month, cur_day, cur_hour, cur_minute, cur_second} = dt(y, mo, d, h, mi, s);
  endtask

  task automatic press(input logic [4:0] mask);
    @(negedge clk);
    {btn_mid, btn_right, btn_left, btn_down, btn_up} = mask;
    repeat (HOLD_CYC) @(negedge clk);
    {btn_mid, btn_right, btn_left, btn_down, btn_up} = '0;
    repeat (HOLD_CYC) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_vec++;
    if (edit_active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %0b expected 0", edit_active); end
    n_vec++;
    if (edit_field !== 3'd3) begin n_err++; $display("FAIL reset_field: got %0d expected 3", edit_field); end
    n_vec++;
    if (load !== 1'b0) begin n_err++; $display("FAIL reset_load: got %0b expected 0", load); end
    n_vec++;
    if (obs !== dt(2000, 1, 1, 0, 0, 0))
      begin n_err++; $display("FAIL reset_values: got %s expected 2000-1-1 0:0:0", fmt(obs)); end
  endtask

  task automatic test_bounce();
    logic seen_active;
    seen_active = 1'b0;
    set_cur(2010, 5, 15, 10, 20, 30);
    for (int seg = 0; seg < 5; seg++) begin
      btn_mid = (seg % 2 == 0);
      repeat (3 * TICK_DIV) begin
        @(negedge clk);
        if (edit_active !== 1'b0) seen_active = 1'b1;
      end
    end
    btn_mid = 1'b1;
    repeat (HOLD_CYC) @(negedge clk);
    n_vec++;
    if (seen_active !== 1'b0) begin n_err++; $display("FAIL bounce_early: got edit during bounce expected none"); end
    n_vec++;
    if (edit_active !== 1'b1) begin n_err++; $display("FAIL bounce_qualify: got %0b expected 1", edit_active); end
    btn_mid = 1'b0;
    repeat (HOLD_CYC) @(negedge clk);
    n_vec++;
    if (edit_active !== 1'b1 || load_cnt != 0)
      begin n_err++; $display("FAIL bounce_single: got active=%0b loads=%0d expected active=1 loads=0", edit_active, load_cnt); end
    n_vec++;
    if (obs !== dt(2010, 5, 15, 10, 20, 30))
      begin n_err++; $display("FAIL bounce_copy: got %s expected 2010-5-15 10:20:30", fmt(obs)); end
  endtask

  task automatic test_reset_mid_edit();
    int lc;
    lc = load_cnt;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (edit_active !== 1'b0 || edit_field !== 3'd3 || load !== 1'b0)
      begin n_err++; $display("FAIL rst_edit_ctrl: got active=%0b field=%0d load=%0b expected 0/3/0", edit_active, edit_field, load); end
    n_vec++;
    if (obs !== dt(2000, 1, 1, 0, 0, 0))
      begin n_err++; $display("FAIL rst_edit_values: got %s expected 2000-1-1 0:0:0", fmt(obs)); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++;
    if (load_cnt != lc) begin n_err++; $display("FAIL rst_edit_noload: got %0d loads expected %0d", load_cnt, lc); end
  endtask

  task automatic test_start_edit();
    set_cur(2023, 2, 28, 23, 59, 59);
    press(M_MID);
    n_vec++;
    if (edit_active !== 1'b1 || edit_field !== 3'd3)
      begin n_err++; $display("FAIL start_ctrl: got active=%0b field=%0d expected 1/3", edit_active, edit_field); end
    n_vec++;
    if (obs !== dt(2023, 2, 28, 23, 59, 59))
      begin n_err++; $display("FAIL start_values: got %s expected 2023-2-28 23:59:59", fmt(obs)); end
  endtask

  task automatic test_wrap_field();
    press(M_UP);
    n_vec++;
    if (obs !== dt(2023, 2, 28, 0, 59, 59))
      begin n_err++; $display("FAIL hour_wrap: got %s expected 2023-2-28 0:59:59", fmt(obs)); end
    repeat (4) press(M_LEFT);
    n_vec++;
    if (edit_field !== 3'd5) begin n_err++; $display("FAIL field_left_wrap: got %0d expected 5", edit_field); end
    press(M_RIGHT);
    n_vec++;
    if (edit_field !== 3'd0) begin n_err++; $display("FAIL field_right_wrap: got %0d expected 0", edit_field); end
  endtask

  task automatic test_day_clamp();
    press(M_MID);
    n_vec++;
    if (edit_active !== 1'b0) begin n_err++; $display("FAIL clamp_exit: got %0b expected 0", edit_active); end
    set_cur(2024, 1, 31, 0, 0, 0);
    press(M_MID);
    repeat (2) press(M_LEFT);
    n_vec++;
    if (edit_field !== 3'd1) begin n_err++; $display("FAIL clamp_field: got %0d expected 1", edit_field); end
    press(M_UP);
    n_vec++;
    if (obs !== dt(2024, 2, 29, 0, 0, 0))
      begin n_err++; $display("FAIL clamp_month: got %s expected 2024-2-29 0:0:0", fmt(obs)); end
    press(M_LEFT);
    press(M_UP);
    n_vec++;
    if (obs !== dt(2025, 2, 28, 0, 0, 0))
      begin n_err++; $display("FAIL clamp_year: got %s expected 2025-2-28 0:0:0", fmt(obs)); end
  endtask

  task automatic test_commit();
    int lc;
    lc = load_cnt;
    press(M_MID);
    n_vec++;
    if (load_cnt != lc + 1) begin n_err++; $display("FAIL commit_pulse: got %0d load cycles expected 1", load_cnt - lc); end
    n_vec++;
    if (load_snap !== dt(2025, 2, 28, 0, 0, 0))
      begin n_err++; $display("FAIL commit_values: got %s expected 2025-2-28 0:0:0", fmt(load_snap)); end
    n_vec++;
    if (edit_active !== 1'b0 || obs !== dt(2025, 2, 28, 0, 0, 0))
      begin n_err++; $display("FAIL commit_after: got active=%0b %s expected 0 2025-2-28 0:0:0", edit_active, fmt(obs)); end
  endtask

  task automatic test_year_wrap();
    set_cur(2150, 12, 31, 12, 34, 56);
    press(M_MID);
    n_vec++;
    if (obs !== dt(2099, 12, 31, 12, 34, 56))
      begin n_err++; $display("FAIL year_sat: got %s expected 2099-12-31 12:34:56", fmt(obs)); end
    repeat (3) press(M_LEFT);
    press(M_UP);
    n_vec++;
    if (edit_year !== 16'd2000 || edit_field !== 3'd0)
      begin n_err++; $display("FAIL year_up_wrap: got %0d field %0d expected 2000 field 0", edit_year, edit_field); end
    press(M_DOWN);
    n_vec++;
    if (edit_year !== 16'd2099) begin n_err++; $display("FAIL year_down_wrap: got %0d expected 2099", edit_year); end
    press(M_UP | M_DOWN);
    n_vec++;
    if (obs !== dt(2099, 12, 31, 12, 34, 56) || edit_field !== 3'd0)
      begin n_err++; $display("FAIL up_down_ignored: got %s field %0d expected 2099-12-31 12:34:56 field 0", fmt(obs), edit_field); end
    repeat (2) press(M_RIGHT);
    press(M_UP);
    n_vec++;
    if (obs !== dt(2099, 12, 1, 12, 34, 56))
      begin n_err++; $display("FAIL day_wrap: got %s expected 2099-12-1 12:34:56", fmt(obs)); end
  endtask

  task automatic test_held_reset();
    int lc;
    do_reset();
    set_cur(2001, 3, 4, 5, 6, 7);
    lc = load_cnt;
    btn_mid = 1'b1;
    repeat (HOLD_CYC) @(negedge clk);
    n_vec++;
    if (edit_active !== 1'b1) begin n_err++; $display("FAIL held_first: got %0b expected 1", edit_active); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_vec++;
    if (edit_active !== 1'b0) begin n_err++; $display("FAIL held_requalify: got %0b expected 0", edit_active); end
    repeat (HOLD_CYC) @(negedge clk);
    btn_mid = 1'b0;
    repeat (HOLD_CYC) @(negedge clk);
    n_vec++;
    if (edit_active !== 1'b1 || load_cnt != lc)
      begin n_err++; $display("FAIL held_press: got active=%0b loads=%0d expected 1/%0d", edit_active, load_cnt, lc); end
    n_vec++;
    if (obs !== dt(2001, 3, 4, 5, 6, 7))
      begin n_err++; $display("FAIL held_values: got %s expected 2001-3-4 5:6:7", fmt(obs)); end
  endtask

  initial begin
    rst = 1'b1;
    {btn_mid, btn_right, btn_left, btn_down, btn_up} = '0;
    set_cur(0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_bounce();
    test_reset_mid_edit();
    test_start_edit();
    test_wrap_field();
    test_day_clamp();
    test_commit();
    test_year_wrap();
    test_held_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
